io_deserializer: RTL and testbench



---
 rtl/io_deserializer.sv | 98 +++++++++
 tb/tb_io_deserializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_deserializer.sv
// Packs swidth-bit symbols MSB-first into pwidth-bit words; last symbol at pad -> POut/PValid two edges later.
// One-word output buffer under valid/ready; a word completing while the buffer is stalled is dropped and flagged sticky in Overflow.
module io_deserializer #(
    parameter int pwidth = 32,
    parameter int swidth = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [swidth-1:0] SIn,
    input  logic              SValid,
    input  logic              Align,
    output logic [pwidth-1:0] POut,
    output logic              PValid,
    input  logic              PReady,
    output logic              Overflow,
    input  logic              ClearOverflow
);

    localparam int N  = pwidth / swidth;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [swidth-1:0]        r_sin_q;
    logic                     r_svalid_q;
    logic [pwidth-swidth-1:0] r_shift;
    logic [CW-1:0]            r_count;
    logic [pwidth-1:0]        r_pout;
    logic                     r_pvalid;
    logic                     r_overflow;

    logic [pwidth-1:0] w_word;
    logic              w_last;
    logic              w_complete;
    logic              w_acc;
    logic              w_drop;

    assign w_word     = {r_shift, r_sin_q};
    assign w_last     = (r_count == LAST);
    assign w_complete = r_svalid_q && !Align && w_last;
    assign w_acc      = r_pvalid && PReady;
    assign w_drop     = w_complete && r_pvalid && !PReady;

    // Pad-side capture stage; deliberately blind to Align.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sin_q    <= '0;
            r_svalid_q <= 1'b0;
        end else begin
            r_sin_q    <= SIn;
            r_svalid_q <= SValid;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (Align) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (r_svalid_q) begin
            if (w_last) begin
                r_count <= '0;
            end else begin
                r_shift <= w_word[pwidth-swidth-1:0];
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Completion and accept on the same edge hands off back-to-back with PValid held high.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pout   <= '0;
            r_pvalid <= 1'b0;
        end else if (w_complete && (!r_pvalid || w_acc)) begin
            r_pout   <= w_word;
            r_pvalid <= 1'b1;
        end else if (!w_complete && w_acc) begin
            r_pvalid <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ClearOverflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign POut     = r_pout;
    assign PValid   = r_pvalid;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_io_deserializer.sv
// Directed bench for io_deserializer: a 32/8 instance for framing, latency, backpressure, Align and reset,
// and an 8/1 instance fed by a serializer model for the bit-serial round trip.
module tb_io_deserializer;

    logic        Clock;
    logic        Reset_n;

    logic [7:0]  a_SIn;
    logic        a_SValid, a_Align, a_PReady, a_ClearOverflow;
    logic [31:0] a_POut;
    logic        a_PValid, a_Overflow;

    logic [0:0]  b_SIn;
    logic        b_SValid, b_Align, b_PReady, b_ClearOverflow;
    logic [7:0]  b_POut;
    logic        b_PValid, b_Overflow;

    int total = 0;
    int bad   = 0;
    int a_pv_cnt = 0;
    int b_pv_cnt = 0;
    int rcv = 0;
    logic [7:0] exp_q[$];

    io_deserializer #(.pwidth(32), .swidth(8)) dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .SIn(a_SIn), .SValid(a_SValid), .Align(a_Align),
        .POut(a_POut), .PValid(a_PValid), .PReady(a_PReady), .Overflow(a_Overflow),
        .ClearOverflow(a_ClearOverflow)
    );

    io_deserializer #(.pwidth(8), .swidth(1)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .SIn(b_SIn), .SValid(b_SValid), .Align(b_Align),
        .POut(b_POut), .PValid(b_PValid), .PReady(b_PReady), .Overflow(b_Overflow),
        .ClearOverflow(b_ClearOverflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        if (a_PValid) a_pv_cnt++;
        if (b_PValid) b_pv_cnt++;
    endtask

    task automatic send_a(input logic [7:0] v);
        a_SIn    = v;
        a_SValid = 1'b1;
        tick();
    endtask

    task automatic idle_a(input int n);
        a_SValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic tick_b();
        tick();
        if (b_PValid) begin
            rcv++;
            if (exp_q.size() > 0) chk("t6_roundtrip", {24'h0, b_POut}, {24'h0, exp_q.pop_front()});
            else chk("t6_extra_word", exp_q.size(), 1);
        end
    endtask

    initial begin
        logic [7:0] t2[4];
        logic [7:0] w;
        logic [7:0] r;
        logic [7:0] bits;

        Reset_n = 1'b0;
        a_SIn = '0; a_SValid = 1'b0; a_Align = 1'b0; a_PReady = 1'b0; a_ClearOverflow = 1'b0;
        b_SIn = '0; b_SValid = 1'b0; b_Align = 1'b0; b_PReady = 1'b0; b_ClearOverflow = 1'b0;
        tick();
        tick();
        chk("rst_a_pout", a_POut, 32'h0);
        chk("rst_a_pvalid", a_PValid, 0);
        chk("rst_a_ovf", a_Overflow, 0);
        chk("rst_b_pout", b_POut, 0);
        chk("rst_b_pvalid", b_PValid, 0);
        Reset_n = 1'b1;
        tick();

        // 1: consecutive symbols, exact latency, single-cycle PValid
        a_PReady = 1'b1;
        a_pv_cnt = 0;
        send_a(8'hDE); send_a(8'hAD); send_a(8'hBE); send_a(8'hEF);
        a_SValid = 1'b0;
        chk("t1_pv_before", a_PValid, 0);
        tick();
        chk("t1_pv_at", a_PValid, 1);
        chk("t1_pout", a_POut, 32'hDEADBEEF);
        tick();
        chk("t1_pv_after", a_PValid, 0);
        chk("t1_pout_hold", a_POut, 32'hDEADBEEF);
        chk("t1_pulses", a_pv_cnt, 1);

        // 2: random gaps between symbols
        t2[0] = 8'h12; t2[1] = 8'h34; t2[2] = 8'h56; t2[3] = 8'h78;
        a_pv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            send_a(t2[i]);
            idle_a($urandom_range(0, 5));
        end
        idle_a(3);
        chk("t2_pout", a_POut, 32'h12345678);
        chk("t2_pulses", a_pv_cnt, 1);

        // 3: stall, drop, accept, clear; then drop coinciding with clear
        a_PReady = 1'b0;
        repeat (4) send_a(8'h11);
        repeat (4) send_a(8'h22);
        idle_a(3);
        chk("t3_pout", a_POut, 32'h11111111);
        chk("t3_pv", a_PValid, 1);
        chk("t3_ovf", a_Overflow, 1);
        a_PReady = 1'b1;
        tick();
        a_PReady = 1'b0;
        chk("t3_pv_acc", a_PValid, 0);
        chk("t3_ovf_sticky", a_Overflow, 1);
        a_ClearOverflow = 1'b1;
        tick();
        a_ClearOverflow = 1'b0;
        chk("t3_ovf_clr", a_Overflow, 0);
        repeat (4) send_a(8'h44);
        idle_a(2);
        repeat (4) send_a(8'h55);
        a_SValid = 1'b0;
        a_ClearOverflow = 1'b1;
        tick();
        a_ClearOverflow = 1'b0;
        chk("t3_set_wins", a_Overflow, 1);
        chk("t3_pout_44", a_POut, 32'h44444444);
        a_PReady = 1'b1;
        tick();
        a_PReady = 1'b0;
        a_ClearOverflow = 1'b1;
        tick();
        a_ClearOverflow = 1'b0;
        chk("t3_ovf_clr2", a_Overflow, 0);
        chk("t3_pv_empty", a_PValid, 0);

        // 4: back-to-back handoff with accept on the completion edge
        send_a(8'hAA); send_a(8'hBB); send_a(8'hCC); send_a(8'hDD);
        send_a(8'h01);
        chk("t4_pv_w1", a_PValid, 1);
        chk("t4_pout_w1", a_POut, 32'hAABBCCDD);
        send_a(8'h02); send_a(8'h03); send_a(8'h04);
        chk("t4_pv_hold", a_PValid, 1);
        chk("t4_pout_hold", a_POut, 32'hAABBCCDD);
        a_SValid = 1'b0;
        a_PReady = 1'b1;
        tick();
        chk("t4_pv_w2", a_PValid, 1);
        chk("t4_pout_w2", a_POut, 32'h01020304);
        chk("t4_ovf", a_Overflow, 0);
        tick();
        chk("t4_pv_done", a_PValid, 0);

        // 5: Align discards a partial word together with an in-flight symbol
        a_pv_cnt = 0;
        send_a(8'hFF); send_a(8'hEE); send_a(8'h77);
        a_SValid = 1'b0;
        a_Align = 1'b1;
        tick();
        a_Align = 1'b0;
        send_a(8'h0A); send_a(8'h0B); send_a(8'h0C); send_a(8'h0D);
        idle_a(3);
        chk("t5_pout", a_POut, 32'h0A0B0C0D);
        chk("t5_pulses", a_pv_cnt, 1);

        // 5b: asynchronous reset mid-word with a held word and Overflow set
        a_PReady = 1'b0;
        repeat (4) send_a(8'h33);
        repeat (4) send_a(8'h66);
        send_a(8'h99); send_a(8'h98);
        chk("t5_pre_ovf", a_Overflow, 1);
        chk("t5_pre_pout", a_POut, 32'h33333333);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t5_rst_pout", a_POut, 32'h0);
        chk("t5_rst_pv", a_PValid, 0);
        chk("t5_rst_ovf", a_Overflow, 0);
        a_SValid = 1'b0;
        tick();
        #2;
        Reset_n = 1'b1;
        a_PReady = 1'b1;
        a_pv_cnt = 0;
        send_a(8'h5A); send_a(8'hC3); send_a(8'h0F); send_a(8'hF0);
        idle_a(3);
        chk("t5_post_pout", a_POut, 32'h5AC30FF0);
        chk("t5_post_pulses", a_pv_cnt, 1);

        // 6: bit-serial 8/1 configuration
        b_PReady = 1'b1;
        b_pv_cnt = 0;
        bits = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) begin
            b_SIn = bits[i];
            b_SValid = 1'b1;
            tick();
        end
        b_SValid = 1'b0;
        repeat (3) tick();
        chk("t6_pout_b2", {24'h0, b_POut}, 32'hB2);
        chk("t6_pulses", b_pv_cnt, 1);

        // 6b: streaming round trip from a parallel-to-serial shift register model
        rcv = 0;
        for (int k = 0; k < 256; k++) begin
            w = 8'($urandom);
            exp_q.push_back(w);
            r = w;
            for (int i = 0; i < 8; i++) begin
                b_SIn = r[7];
                b_SValid = 1'b1;
                r = {r[6:0], 1'b0};
                tick_b();
            end
        end
        b_SValid = 1'b0;
        repeat (4) tick_b();
        chk("t6_rcv_count", rcv, 256);
        chk("t6_b_ovf", b_Overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
